fifo_buffer_param: RTL and testbench

- Parametrised successor to the team's basic synchronous FIFO.
- Adds: selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, programmable almost_full and almost_empty thresholds, sticky overflow and underflow flags, and a synchronous flush.
- Single clock domain.
- Used as the general-purpose buffer between streaming stages in the same design.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_buffer_param.sv | 152 +++++++++++++++
 tb/tb_fifo_buffer_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: read-mode constants and pointer sizing.
// Latency: n/a (compile-time constants and a constant function only).
// Backpressure: n/a.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointer width for a given depth: address bits plus one wrap bit.
  // The wrap bit is what tells full (same address, different lap) from empty.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: WIDTH x DEPTH, one synchronous write port, one asynchronous read port.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none; the owner must only write free slots.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  // Contents are deliberately not reset; occupancy tracking decides what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the tail address on the rising edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with standard/FWFT read, occupancy, thresholds, sticky errors, flush.
// Latency: standard mode data 1 cycle after an accepted read; FWFT head visible the cycle after its write.
// Backpressure: writes while full and reads while empty are dropped and flagged. FIFO_PEAK_LEVEL_EN enables the high-watermark register.
module fifo_buffer_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_en,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              read_en,
  input  logic                              flush,
  input  logic                              clear_err,
  output logic [WIDTH-1:0]                  data_out,
  output logic                              data_valid,
  output logic                              empty,
  output logic                              full,
  output logic                              almost_empty,
  output logic                              almost_full,
  output logic [fifo_ptr_width(DEPTH)-1:0]  count,
  output logic                              overflow,
  output logic                              underflow,
  output logic [fifo_ptr_width(DEPTH)-1:0]  peak_level
);

  localparam int PW = fifo_ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             wr_acc, rd_acc;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] rd_data;

  // Accept/reject decisions use pre-edge full/empty; flush suppresses traffic and errors
  always_comb begin
    wr_acc  = write_en && !full  && !flush;
    rd_acc  = read_en  && !empty && !flush;
    ovf_set = write_en &&  full  && !flush;
    unf_set = read_en  &&  empty && !flush;
  end

  // Next pointer and occupancy values, shared by the state registers and the watermark
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      wr_ptr_nxt = wr_ptr + PW'(wr_acc);
      rd_ptr_nxt = rd_ptr + PW'(rd_acc);
      count_nxt  = count + PW'(wr_acc) - PW'(rd_acc);
    end
  end

  // Pointer, count and full/empty state; full/empty come from the next pointers' lap bits
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[PW-1]   != rd_ptr_nxt[PW-1]);
    end
  end

  // Sticky error flags: clear_err drops them, a new error in the same cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_err) || ovf_set;
      underflow <= (underflow && !clear_err) || unf_set;
    end
  end

  // Threshold flags are plain decodes of the registered count
  always_comb begin
    almost_full  = (int'(count) >= AF_LEVEL);
    almost_empty = (int'(count) <= AE_LEVEL);
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head entry is shown directly; forced to zero while empty so stale memory never leaks out
      assign data_out   = empty ? '0 : rd_data;
      assign data_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             vld_q;

      // Registered read: load the head on an accepted read, valid pulses for one cycle
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= rd_data;
          end
        end
      end

      assign data_out   = dout_q;
      assign data_valid = vld_q;
    end
  endgenerate

`ifdef FIFO_PEAK_LEVEL_EN
  // High-watermark of occupancy; flush leaves it alone since the next count is then zero
  always_ff @(posedge clk) begin
    if (reset || clear_err) begin
      peak_level <= '0;
    end else if (count_nxt > peak_level) begin
      peak_level <= count_nxt;
    end
  end
`else
  assign peak_level = '0;
`endif

endmodule

// File: tb/tb_fifo_buffer_param.sv
module tb_fifo_buffer_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, write_en, read_en, flush, clear_err;
  logic [W-1:0]  data_in;

  logic [W-1:0]  s_data_out, f_data_out;
  logic          s_data_valid, f_data_valid;
  logic          s_empty, s_full, s_almost_empty, s_almost_full, s_overflow, s_underflow;
  logic          f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
  logic [CW-1:0] s_count, f_count, s_peak_level, f_peak_level;

  always #5 clk = ~clk;

  fifo_buffer_param #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_std (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .flush(flush), .clear_err(clear_err), .data_out(s_data_out), .data_valid(s_data_valid),
    .empty(s_empty), .full(s_full), .almost_empty(s_almost_empty), .almost_full(s_almost_full),
    .count(s_count), .overflow(s_overflow), .underflow(s_underflow), .peak_level(s_peak_level)
  );

  fifo_buffer_param #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_fwft (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .flush(flush), .clear_err(clear_err), .data_out(f_data_out), .data_valid(f_data_valid),
    .empty(f_empty), .full(f_full), .almost_empty(f_almost_empty), .almost_full(f_almost_full),
    .count(f_count), .overflow(f_overflow), .underflow(f_underflow), .peak_level(f_peak_level)
  );

  // Reference model: a queue of words plus the spec-level sticky/observable state
  logic [W-1:0] q[$];
  logic         m_ov, m_un, m_dv;
  logic [W-1:0] m_dout;
  int           m_peak;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic we, input logic [W-1:0] din,
                       input logic re, input logic fl, input logic ce);
    bit was_full, was_empty;
    if (rst) begin
      q.delete();
      m_ov = 0; m_un = 0; m_dv = 0; m_dout = '0; m_peak = 0;
    end else if (fl) begin
      q.delete();
      m_dv = 0;
      if (ce) begin m_ov = 0; m_un = 0; m_peak = 0; end
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      m_dv = 0;
      if (re && !was_empty) begin
        m_dout = q.pop_front();
        m_dv   = 1;
      end
      if (we && !was_full) q.push_back(din);
      m_ov = (m_ov && !ce) || (we && was_full);
      m_un = (m_un && !ce) || (re && was_empty);
      if (ce) m_peak = 0;
      else if (q.size() > m_peak) m_peak = q.size();
    end
  endtask

  task automatic check_all();
    chk("count",       s_count,        q.size());
    chk("fwft_count",  f_count,        q.size());
    chk("empty",       s_empty,        q.size() == 0);
    chk("full",        s_full,         q.size() == D);
    chk("almost_empty", s_almost_empty, q.size() <= AE);
    chk("almost_full", s_almost_full,  q.size() >= AF);
    chk("overflow",    s_overflow,     m_ov);
    chk("underflow",   s_underflow,    m_un);
    chk("std_valid",   s_data_valid,   m_dv);
    chk("std_dout",    s_data_out,     m_dout);
    chk("fwft_valid",  f_data_valid,   q.size() != 0);
    if (q.size() != 0) chk("fwft_dout", f_data_out, q[0]);
`ifdef FIFO_PEAK_LEVEL_EN
    chk("peak", s_peak_level, m_peak);
`else
    chk("peak_tied", s_peak_level, 0);
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge
  task automatic step(input logic rst, input logic we, input logic [W-1:0] din,
                      input logic re, input logic fl, input logic ce);
    reset = rst; write_en = we; data_in = din; read_en = re; flush = fl; clear_err = ce;
    @(posedge clk);
    model(rst, we, din, re, fl, ce);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int wbias, rbias;
    reset = 1; write_en = 0; data_in = '0; read_en = 0; flush = 0; clear_err = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_ae", s_almost_empty, 1);

    // Fill 0x00..0x0F, then one write too many
    for (int i = 0; i < D; i++) begin
      step(0, 1, W'(i), 0, 0, 0);
      if (i == 12) chk("af_below_14", s_almost_full, 0);
      if (i == 13) chk("af_at_14", s_almost_full, 1);
    end
    chk("fill_count", s_count, 16);
    chk("fill_full", s_full, 1);
    step(0, 1, 8'hEE, 0, 0, 0);
    chk("ovf_set", s_overflow, 1);
    chk("ovf_count", s_count, 16);

    // Drain in order, then one read too many
    for (int i = 0; i < D; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("drain_data", s_data_out, i);
      chk("drain_valid", s_data_valid, 1);
    end
    chk("drain_empty", s_empty, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("unf_set", s_underflow, 1);
    chk("unf_hold", s_data_out, 8'h0F);
    chk("unf_valid", s_data_valid, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("clr_ovf", s_overflow, 0);
    chk("clr_unf", s_underflow, 0);

    // Simultaneous read/write at count 8 across the pointer wrap
    for (int i = 0; i < 8; i++) step(0, 1, W'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, W'(8'h50 + i), 1, 0, 0);
      chk("rw_count", s_count, 8);
    end

    // Flush at count 10 with a write pending
    step(0, 1, 8'h60, 0, 0, 0);
    step(0, 1, 8'h61, 0, 0, 0);
    chk("pre_flush", s_count, 10);
    step(0, 1, 8'hAA, 0, 1, 0);
    chk("flush_count", s_count, 0);
    chk("flush_empty", s_empty, 1);
    chk("flush_noovf", s_overflow, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_unf", s_underflow, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("flush_clr", s_underflow, 0);

    // FWFT: word appears the cycle after the write; pop drops valid as empty rises
    step(0, 1, 8'hA5, 0, 0, 0);
    chk("fwft_a5", f_data_out, 8'hA5);
    chk("fwft_a5_vld", f_data_valid, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("fwft_pop_vld", f_data_valid, 0);
    chk("fwft_pop_empty", f_empty, 1);

    // Reset mid-operation at count 5
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, W'(8'h70 + i), 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 8'h75, 0, 0, 0);
    chk("pre_rst_count", s_count, 5);
`ifdef FIFO_PEAK_LEVEL_EN
    chk("pre_rst_peak", s_peak_level, 5);
`endif
    step(1, 1, 8'h99, 1, 0, 0);
    chk("mid_rst_count", s_count, 0);
    chk("mid_rst_dout", s_data_out, 0);
    chk("mid_rst_empty", s_empty, 1);
    chk("mid_rst_full", s_full, 0);
    chk("mid_rst_af", s_almost_full, 0);
`ifdef FIFO_PEAK_LEVEL_EN
    chk("mid_rst_peak", s_peak_level, 0);
`endif

    // Randomized traffic in phases biased toward filling or draining
    wbias = 50; rbias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        wbias = $urandom_range(10, 95);
        rbias = $urandom_range(10, 95);
      end
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < wbias),
           W'($urandom),
           ($urandom_range(0, 99) < rbias),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
